acc_pass_sequencer: RTL and testbench

//  Sequences one matrix-multiply pass of the NxN systolic array: weight load,

---
 rtl/acc_pass_sequencer.sv | 178 +++++++++++++++++
 tb/tb_acc_pass_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_pass_sequencer.sv
// Pass sequencer for the NxN systolic array. It runs one pass in this order: weight load,
// skewed input streaming, a wait for every column accumulator to report full, then a
// word-serial drain of the results to the output buffer.
// Optional feature: define ACC_SEQ_TIMEOUT_EN to bound the WAIT_FULL dwell to TIMEOUT
// cycles. When the bound expires, the pass ends with a sticky err and no drain.
module acc_pass_sequencer #(
  parameter int unsigned N       = 2,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned RowW   = $clog2(N),
  localparam int unsigned StepW  = $clog2(2 * N)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          out_base_i,
  input  logic [N-1:0]               acc_full_i,
  input  logic [N*N*DATA_W-1:0]      acc_data_i,
  output logic                       load_w_o,
  output logic [RowW-1:0]            w_row_o,
  output logic                       in_valid_o,
  output logic [StepW-1:0]           in_step_o,
  output logic                       acc_valid_o,
  output logic                       acc_clear_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ADDR_W-1:0]          out_addr_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int unsigned Beats = N * N;
  // A single counter serves as row index, skew step, timeout count and beat index.
  localparam int unsigned CntW  = $clog2(Beats + 2 * N + TIMEOUT + 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StLoadW    = 3'd1;
  localparam logic [2:0] StStream   = 3'd2;
  localparam logic [2:0] StWaitFull = 3'd3;
  localparam logic [2:0] StDrain    = 3'd4;
  localparam logic [2:0] StDone     = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              all_full;
  logic [DATA_W-1:0] word_sel;

  assign all_full = &acc_full_i;

`ifdef ACC_SEQ_TIMEOUT_EN
  logic err_q, err_d;
`endif

  // Next-state, counter and latched-base logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
`ifdef ACC_SEQ_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d  = out_base_i;
          cnt_d   = '0;
          state_d = StLoadW;
`ifdef ACC_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      StLoadW: begin
        if (cnt_q == CntW'(N - 1)) begin
          cnt_d   = '0;
          state_d = StStream;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStream: begin
        if (cnt_q == CntW'(2 * N - 2)) begin
          cnt_d   = '0;
          state_d = StWaitFull;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitFull: begin
        if (all_full) begin
          cnt_d   = '0;
          state_d = StDrain;
`ifdef ACC_SEQ_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // Give up on this pass: skip the drain and report the error.
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDrain: begin
        if (out_ready_i) begin
          if (cnt_q == CntW'(Beats - 1)) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers. Reset aborts any pass in progress.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

`ifdef ACC_SEQ_TIMEOUT_EN
  // Sticky timeout flag. It is cleared only when a new start is accepted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Result-word mux. The beat index is stable while stalled, so the word is too.
  always_comb begin
    word_sel = '0;
    for (int k = 0; k < int'(Beats); k++) begin
      if (cnt_q == CntW'(k)) word_sel = acc_data_i[k*DATA_W +: DATA_W];
    end
  end

  // Moore outputs. Everything except busy is forced to zero outside its own state.
  always_comb begin
    load_w_o    = (state_q == StLoadW);
    w_row_o     = load_w_o ? cnt_q[RowW-1:0] : '0;
    in_valid_o  = (state_q == StStream);
    in_step_o   = in_valid_o ? cnt_q[StepW-1:0] : '0;
    acc_valid_o = (state_q == StStream) || (state_q == StWaitFull);
    out_valid_o = (state_q == StDrain);
    out_addr_o  = out_valid_o ? (base_q + ADDR_W'(cnt_q)) : '0;
    out_data_o  = out_valid_o ? word_sel : '0;
    done_o      = (state_q == StDone);
    acc_clear_o = done_o;
    busy_o      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_acc_pass_sequencer.sv
// Bench for acc_pass_sequencer (N=2). When a pass starts, its expected result beats go into
// a scoreboard queue. A negedge monitor pops and checks one beat per accepted transfer.
module tb_acc_pass_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [7:0]  out_base;
  logic [1:0]  acc_full;
  logic [31:0] acc_data;
  logic        load_w, in_valid, acc_valid, acc_clear, out_valid, busy, done, err;
  logic [0:0]  w_row;
  logic [1:0]  in_step;
  logic [7:0]  out_addr, out_data;

  int total = 0;
  int bad   = 0;
  int ld_cnt = 0, iv_cnt = 0, av_cnt = 0, beat_cnt = 0, done_cnt = 0;
  int exp_row = 0, exp_step = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_addr, prev_data;

  always #5 clk = ~clk;

  acc_pass_sequencer dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .out_base_i  (out_base),
    .acc_full_i  (acc_full),
    .acc_data_i  (acc_data),
    .load_w_o    (load_w),
    .w_row_o     (w_row),
    .in_valid_o  (in_valid),
    .in_step_o   (in_step),
    .acc_valid_o (acc_valid),
    .acc_clear_o (acc_clear),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_addr_o  (out_addr),
    .out_data_o  (out_data),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs_vec();
    return {5'd0, load_w, w_row, in_valid, in_step, acc_valid, acc_clear, out_valid,
            out_addr, out_data, busy, done, err};
  endfunction

  task automatic push_expected(input logic [7:0] base, input logic [31:0] dat);
    for (int k = 0; k < 4; k++) exp_q.push_back({base + 8'(k), dat[k*8 +: 8]});
  endtask

  // Monitor: sequence indices, strobe counts, stall hold and scoreboard pops.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      exp_row    = 0;
      exp_step   = 0;
    end else begin
      if (load_w) begin
        chk("w_row", 32'(w_row), exp_row);
        exp_row++;
        ld_cnt++;
      end else exp_row = 0;
      if (in_valid) begin
        chk("in_step", 32'(in_step), exp_step);
        exp_step++;
        iv_cnt++;
      end else exp_step = 0;
      if (acc_valid) av_cnt++;
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_addr", 32'(out_addr), 32'(prev_addr));
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(exp_q.size()), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_addr", 32'(out_addr), 32'(mon_e[15:8]));
          chk("beat_data", 32'(out_data), 32'(mon_e[7:0]));
        end
        beat_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_data  = out_data;
    end
  end

  // One full pass. rdy_pat[i%4] drives out_ready on drain cycle i. mid_start pulses start
  // once in STREAM and once in DRAIN.
  task automatic run_pass(input logic [7:0] base, input logic [3:0] rdy_pat,
                          input bit mid_start, input bit chk_lat);
    int ld0, iv0, bt0, dn0, n, dr;
    bit got;
    logic [31:0] dat;
    dat      = $urandom;
    acc_data = dat;
    out_base = base;
    push_expected(base, dat);
    ld0 = ld_cnt; iv0 = iv_cnt; bt0 = beat_cnt; dn0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    chk("busy_after_start", 32'(busy), 1);
    chk("err_after_start", 32'(err), 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (in_valid) got = 1'b1;
      else begin
        step();
        n++;
      end
    end
    chk("stream_seen", 32'(got), 1);
    if (mid_start) start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n++;
      start = 1'b0;
    end
    acc_full = 2'b11;
    dr  = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (out_valid) begin
          out_ready = rdy_pat[dr % 4];
          start     = (mid_start && dr == 1);
          dr++;
        end else begin
          out_ready = 1'b1;
          start     = 1'b0;
        end
        step();
        n++;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 1);
    if (chk_lat) chk("latency", n, 11);
    chk("clear_with_done", 32'(acc_clear), 1);
    chk("busy_in_done", 32'(busy), 1);
    step();
    chk("idle_after_done", 32'(busy), 0);
    chk("load_w_cycles", ld_cnt - ld0, 2);
    chk("in_valid_cycles", iv_cnt - iv0, 3);
    chk("beats", beat_cnt - bt0, 4);
    chk("done_pulses", done_cnt - dn0, 1);
    chk("queue_empty", 32'(exp_q.size()), 0);
    acc_full  = 2'b00;
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; out_base = 8'h00;
    acc_full = 2'b00; acc_data = 32'h0;
    step();
    step();
    chk("reset_outputs", outs_vec(), 0);
    reset = 1'b0;
    step();
    chk("idle_outputs", outs_vec(), 0);

    // Basic pass, ready always high, including the start-to-done latency.
    run_pass(8'h10, 4'b1111, 1'b0, 1'b1);
    // Drain backpressure with ready pattern 1,0,0,1.
    run_pass(8'h40, 4'b1001, 1'b0, 1'b0);
    // Address wrap.
    run_pass(8'hFE, 4'b1111, 1'b0, 1'b0);
    // Start pulses in STREAM and in DRAIN must be ignored.
    run_pass(8'h20, 4'b1101, 1'b1, 1'b0);

    // Reset in the middle of a drain, once two beats have been accepted.
    acc_data = $urandom;
    out_base = 8'h80;
    push_expected(8'h80, acc_data);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    acc_full = 2'b11;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (out_valid && out_addr == 8'h82) got = 1'b1;
      else step();
    end
    chk("third_beat_reached", 32'(got), 1);
    reset = 1'b1;
    #1;
    chk("abort_outputs", outs_vec(), 0);
    step();
    chk("abort_outputs_next", outs_vec(), 0);
    exp_q.delete();
    reset    = 1'b0;
    acc_full = 2'b00;
    step();
    run_pass(8'h33, 4'b1111, 1'b0, 1'b0);

`ifdef ACC_SEQ_TIMEOUT_EN
    begin
      int av0, bt0, dn0;
      acc_full = 2'b01;
      av0 = av_cnt; bt0 = beat_cnt; dn0 = done_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
        if (done) got = 1'b1;
        else step();
      end
      chk("timeout_done", 32'(got), 1);
      chk("timeout_err", 32'(err), 1);
      chk("timeout_clear", 32'(acc_clear), 1);
      step();
      chk("timeout_acc_valid_cycles", av_cnt - av0, 67);
      chk("timeout_no_beats", beat_cnt - bt0, 0);
      chk("timeout_done_pulses", done_cnt - dn0, 1);
      chk("err_sticky", 32'(err), 1);
      acc_full = 2'b00;
      run_pass(8'h50, 4'b1111, 1'b0, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
